// File: rtl/winograd_tile_stream.sv
// rtl/winograd_tile_stream.sv - streaming 3x3 valid cross-correlation over an (OUT_T+2)^2 tile with cached kernel
module winograd_tile_stream #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int OUT_T  = 4,
  parameter int SIGNED = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             kernel_load,
  input  logic [0:2][0:2][DATA_W-1:0]      kernel_in,
  output logic                             kernel_ready,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_data,
  output logic [$clog2(OUT_T+1)-1:0]       out_row,
  output logic [$clog2(OUT_T+1)-1:0]       out_col,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done
);

  localparam int IN_T = OUT_T + 2;
  localparam int NE   = IN_T * IN_T;
  localparam int CW   = $clog2(NE + 1);
  localparam int RW   = $clog2(OUT_T + 1);
  // Nine full products plus carry headroom; never narrower than the result.
  localparam int PW   = 2 * DATA_W + 4;
  localparam int SW   = (PW > ACC_W) ? PW : ACC_W;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]                    state;
  logic [CW-1:0]                 in_count;
  logic [0:2][0:2][DATA_W-1:0]   kernel;
  logic [DATA_W-1:0]             tile [NE];

  logic                          hs_in;
  logic                          hs_out;
  logic                          last_col;
  logic [RW-1:0]                 next_r;
  logic [RW-1:0]                 next_c;
  logic                          next_last;
  logic [SW-1:0]                 acc;

  // Operands are extended to the sum width; wrapping multiply then gives exact low bits.
  function automatic logic [SW-1:0] ext(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) ext = {{(SW-DATA_W){v[DATA_W-1]}}, v};
    else             ext = {{(SW-DATA_W){1'b0}}, v};
  endfunction

  assign in_ready     = (state == S_FILL);
  assign kernel_ready = (state == S_FILL) && (in_count == '0);
  assign out_valid    = (state == S_EMIT);
  assign busy         = (state != S_FILL) || (in_count != '0);
  assign hs_in        = in_valid && in_ready;
  assign hs_out       = out_valid && out_ready;
  assign last_col     = (out_col == RW'(OUT_T - 1));

  // Coordinates of the element to register next: (0,0) from CALC, row-major successor in EMIT.
  always_comb begin
    next_r = '0;
    next_c = '0;
    if (state == S_EMIT && !out_last) begin
      if (last_col) begin
        next_r = out_row + 1'b1;
        next_c = '0;
      end else begin
        next_r = out_row;
        next_c = out_col + 1'b1;
      end
    end
    next_last = (next_r == RW'(OUT_T - 1)) && (next_c == RW'(OUT_T - 1));
  end

  // Direct 9-tap MAC for the selected output position.
  always_comb begin
    logic [CW-1:0] idx;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        idx = CW'((int'(next_r) + i) * IN_T + int'(next_c) + j);
        acc = acc + ext(kernel[i][j]) * ext(tile[idx]);
      end
    end
  end

  // Tile buffer write; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (hs_in) tile[in_count] <= in_data;
  end

  // Control state, kernel cache and registered output element.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      in_count <= '0;
      kernel   <= '0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kernel_load && kernel_ready) kernel <= kernel_in;
      case (state)
        S_FILL: begin
          if (hs_in) begin
            if (in_count == CW'(NE - 1)) begin
              in_count <= '0;
              state    <= S_CALC;
            end else begin
              in_count <= in_count + 1'b1;
            end
          end
        end
        S_CALC: begin
          out_data <= acc[ACC_W-1:0];
          out_row  <= next_r;
          out_col  <= next_c;
          out_last <= next_last;
          state    <= S_EMIT;
        end
        S_EMIT: begin
          if (hs_out) begin
            if (out_last) begin
              out_last <= 1'b0;
              done     <= 1'b1;
              state    <= S_FILL;
            end else begin
              out_data <= acc[ACC_W-1:0];
              out_row  <= next_r;
              out_col  <= next_c;
              out_last <= next_last;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
